// File: rtl/rcadder_pkg.sv
// rtl/rcadder_pkg.sv - shared types and constants for the nibble-serial add/sub sequencer
package rcadder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Nibble index counter width; a single-nibble datapath still needs one bit.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/rcadder.sv
// rtl/rcadder.sv - 4-bit ripple-carry adder slice, purely combinational
module rcadder
  import rcadder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[SLICE_W];
  end

endmodule

// File: rtl/rcadder_seq_ctrl.sv
// rtl/rcadder_seq_ctrl.sv - WIDTH-bit add/subtract computed one nibble per clock on a shared slice
module rcadder_seq_ctrl
  import rcadder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / SLICE_W;
  localparam int IW  = idx_width(NIB);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("rcadder_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  logic [SLICE_W-1:0]       slice_sum;
  logic                     slice_co;
  logic [WIDTH+SLICE_W-1:0] res_shift;

  // Slice sees only registered operands so its path never starts at a port.
  rcadder u_slice (
    .a  (a_q[SLICE_W-1:0]),
    .b  (b_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_co)
  );

  assign res_shift = {slice_sum, res_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin;
          a_msb_d = op_a[WIDTH-1];
          b_msb_d = sub ? ~op_b[WIDTH-1] : op_b[WIDTH-1];
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // LSB nibble first: after NIB shifts the result register is fully assembled.
        res_d   = res_shift[WIDTH+SLICE_W-1:SLICE_W];
        a_d     = a_q >> SLICE_W;
        b_d     = b_q >> SLICE_W;
        carry_d = slice_co;
        if (idx_q == IW'(NIB - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign sum  = res_q;
  assign cout = carry_q;
  assign ovf  = (a_msb_q == b_msb_q) && (res_q[WIDTH-1] != a_msb_q);

endmodule
